// File: rtl/demux_route_pkg.sv
// Shared types and constants for the demux route sequencer.
//   state_e      : sequencer state (idle, strobe window, guard gap)
//   NCH_DEFAULT  : default number of demux channels
//   AW_DEFAULT   : default address width
//   STAT_W       : width of the optional delivery/drop statistics counters
//   cnt_width()  : minimum counter width able to hold a given value
package demux_route_pkg;

  localparam int unsigned NCH_DEFAULT = 8;
  localparam int unsigned AW_DEFAULT  = 3;
  localparam int unsigned STAT_W      = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } state_e;

  // Minimum number of bits able to represent 'value' (at least 1).
  function automatic int unsigned cnt_width(input int unsigned value);
    int unsigned w;
    w = $clog2(value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_route_sequencer_if.sv
// Handshake input and demux-facing output bus of the route sequencer.
//   in_valid/in_ready/in_bit/in_addr : word handshake and payload
//   mode, chan_mask                  : routing controls, sampled at accept
//   out_addr/out_data/out_strobe     : demux select, gated data, window
// Modports: master drives words and observes the demux side; slave is the sequencer.
interface demux_route_sequencer_if #(
  parameter int unsigned NCH = 8,
  parameter int unsigned AW  = 3
);
  logic           in_valid;
  logic           in_ready;
  logic           in_bit;
  logic [AW-1:0]  in_addr;
  logic           mode;
  logic [NCH-1:0] chan_mask;
  logic [AW-1:0]  out_addr;
  logic           out_data;
  logic           out_strobe;

  modport master (
    output in_valid, in_bit, in_addr, mode, chan_mask,
    input  in_ready, out_addr, out_data, out_strobe
  );

  modport slave (
    input  in_valid, in_bit, in_addr, mode, chan_mask,
    output in_ready, out_addr, out_data, out_strobe
  );
endinterface

// File: rtl/rr_next_chan.sv
// Combinational round-robin search: first enabled channel strictly after
// last_ptr, wrapping modulo NCH.
//   mask      : channel enable bits
//   last_ptr  : previously granted channel
//   grant     : next channel to serve (valid only when any_valid)
//   any_valid : at least one channel enabled
module rr_next_chan #(
  parameter int unsigned NCH = 8,
  parameter int unsigned AW  = 3
) (
  input  logic [NCH-1:0] mask,
  input  logic [AW-1:0]  last_ptr,
  output logic [AW-1:0]  grant,
  output logic           any_valid
);

  logic [AW-1:0] cand;

  // Walk offsets from far to near so the nearest enabled channel after
  // last_ptr is the last one written. Offset NCH wraps to last_ptr itself,
  // which lets a single enabled channel be granted repeatedly.
  always_comb begin
    grant = '0;
    cand  = '0;
    for (int i = NCH; i >= 1; i--) begin
      cand = last_ptr + AW'(i);
      if (mask[cand]) begin
        grant = cand;
      end
    end
  end

  assign any_valid = |mask;

endmodule

// File: rtl/demux_route_sequencer.sv
// Upstream feeder for the 8-way demux tree. Accepts single-bit words over a
// valid/ready handshake, picks a channel (round-robin or explicit), drives the
// demux select and gated data for STROBE_LEN cycles, then idles GAP_CYCLES.
//   clk, rst_n  : clock and asynchronous active-low reset
//   bus         : handshake input and demux output (slave modport)
//   busy        : high while delivering or in the guard gap
//   err_drop    : one-cycle pulse when an explicit word targets a masked channel
// Optional (macro DEMUX_ROUTE_STATS_EN):
//   stat_sel    : channel whose delivery count is read on stat_count
//   stat_count  : saturating delivery count of channel stat_sel
//   drop_count  : saturating count of dropped words
module demux_route_sequencer
  import demux_route_pkg::*;
#(
  parameter int unsigned NCH        = NCH_DEFAULT,
  parameter int unsigned AW         = AW_DEFAULT,
  parameter int unsigned STROBE_LEN = 1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_route_sequencer_if.slave  bus,
`ifdef DEMUX_ROUTE_STATS_EN
  input  logic [AW-1:0]           stat_sel,
  output logic [STAT_W-1:0]       stat_count,
  output logic [STAT_W-1:0]       drop_count,
`endif
  output logic                    busy,
  output logic                    err_drop
);

  localparam int unsigned MaxLen = (STROBE_LEN > GAP_CYCLES) ? STROBE_LEN : GAP_CYCLES;
  localparam int unsigned CW     = cnt_width(MaxLen);
  localparam logic [CW-1:0] StrobeLoad = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] GapLoad    = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] last_ptr_q;
  logic [AW-1:0] out_addr_q;
  logic          out_data_q;
  logic          out_strobe_q;
  logic          err_drop_q;

  logic [AW-1:0] rr_grant;
  logic          rr_any;
  logic          accept;

  rr_next_chan #(
    .NCH (NCH),
    .AW  (AW)
  ) u_rr_next_chan (
    .mask      (bus.chan_mask),
    .last_ptr  (last_ptr_q),
    .grant     (rr_grant),
    .any_valid (rr_any)
  );

  // Explicit mode is always ready; masked targets are consumed and dropped.
  assign bus.in_ready = (state_q == StIdle) && (bus.mode || rr_any);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_ptr_q   <= AW'(NCH - 1);
      out_addr_q   <= '0;
      out_data_q   <= 1'b0;
      out_strobe_q <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      err_drop_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.mode) begin
              if (bus.chan_mask[bus.in_addr]) begin
                out_addr_q   <= bus.in_addr;
                out_data_q   <= bus.in_bit;
                out_strobe_q <= 1'b1;
                cnt_q        <= StrobeLoad;
                state_q      <= StDrive;
              end else begin
                err_drop_q <= 1'b1;
              end
            end else begin
              out_addr_q   <= rr_grant;
              last_ptr_q   <= rr_grant;
              out_data_q   <= bus.in_bit;
              out_strobe_q <= 1'b1;
              cnt_q        <= StrobeLoad;
              state_q      <= StDrive;
            end
          end
        end
        StDrive: begin
          if (cnt_q == '0) begin
            out_strobe_q <= 1'b0;
            out_data_q   <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_q <= StIdle;
            end else begin
              cnt_q   <= GapLoad;
              state_q <= StGap;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_addr   = out_addr_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_strobe = out_strobe_q;
  assign busy           = (state_q != StIdle);
  assign err_drop       = err_drop_q;

`ifdef DEMUX_ROUTE_STATS_EN
  logic [STAT_W-1:0] stat_cnt_q [NCH];
  logic [STAT_W-1:0] drop_cnt_q;
  logic              first_drive;

  // The window counter starts at StrobeLoad, so it only equals it on the
  // first DRIVE cycle of a delivery.
  assign first_drive = (state_q == StDrive) && (cnt_q == StrobeLoad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        stat_cnt_q[i] <= '0;
      end
      drop_cnt_q <= '0;
    end else begin
      if (first_drive && (stat_cnt_q[out_addr_q] != '1)) begin
        stat_cnt_q[out_addr_q] <= stat_cnt_q[out_addr_q] + STAT_W'(1);
      end
      if (err_drop_q && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + STAT_W'(1);
      end
    end
  end

  assign stat_count = stat_cnt_q[stat_sel];
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_route_sequencer.sv
// Directed bench for demux_route_sequencer: a default-parameter instance and a
// STROBE_LEN=3 / GAP_CYCLES=0 instance, each with its own reset.
module tb_demux_route_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n;
  logic busy0, err0, busy1, err1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  demux_route_sequencer_if #(.NCH(8), .AW(3)) b0 ();
  demux_route_sequencer_if #(.NCH(8), .AW(3)) b1 ();

`ifdef DEMUX_ROUTE_STATS_EN
  logic [2:0] ssel0, ssel1;
  logic [7:0] scnt0, dcnt0, scnt1, dcnt1;
`endif

  demux_route_sequencer #(
    .NCH(8), .AW(3), .STROBE_LEN(1), .GAP_CYCLES(1)
  ) u_dut0 (
    .clk        (clk),
    .rst_n      (rst0_n),
    .bus        (b0),
`ifdef DEMUX_ROUTE_STATS_EN
    .stat_sel   (ssel0),
    .stat_count (scnt0),
    .drop_count (dcnt0),
`endif
    .busy       (busy0),
    .err_drop   (err0)
  );

  demux_route_sequencer #(
    .NCH(8), .AW(3), .STROBE_LEN(3), .GAP_CYCLES(0)
  ) u_dut1 (
    .clk        (clk),
    .rst_n      (rst1_n),
    .bus        (b1),
`ifdef DEMUX_ROUTE_STATS_EN
    .stat_sel   (ssel1),
    .stat_count (scnt1),
    .drop_count (dcnt1),
`endif
    .busy       (busy1),
    .err_drop   (err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Waits (bounded) at negedges until dut0 is ready; records the accept cycle.
  task automatic wait_ready0(input string tag);
    int n = 0;
    while (!b0.in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rdy"}, 32'(b0.in_ready), 1);
    acc_cyc = cyc;
  endtask

  // One delivery on dut0 with in_valid already high; checks the first strobe cycle.
  task automatic deliver0(input string tag, input int exp_addr, input logic exp_data);
    wait_ready0(tag);
    @(negedge clk);
    check_eq({tag, "_stb"},  32'(b0.out_strobe), 1);
    check_eq({tag, "_addr"}, 32'(b0.out_addr), exp_addr);
    check_eq({tag, "_data"}, 32'(b0.out_data), 32'(exp_data));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int w;
    int a1;
    int seq_sparse [4] = '{2, 5, 7, 2};

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    b0.in_valid = 1'b0; b0.in_bit = 1'b0; b0.in_addr = '0; b0.mode = 1'b0; b0.chan_mask = 8'hFF;
    b1.in_valid = 1'b0; b1.in_bit = 1'b0; b1.in_addr = '0; b1.mode = 1'b0; b1.chan_mask = 8'hFF;
`ifdef DEMUX_ROUTE_STATS_EN
    ssel0 = '0;
    ssel1 = '0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_addr", 32'(b0.out_addr), 0);
    check_eq("rst_stb",  32'(b0.out_strobe), 0);
    check_eq("rst_data", 32'(b0.out_data), 0);
    check_eq("rst_busy", 32'(busy0), 0);
    check_eq("rst_err",  32'(err0), 0);
    rst0_n = 1'b1;
    @(negedge clk);

    // Round-robin walk over a full mask, one accept every 3 cycles.
    b0.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      prev = acc_cyc;
      b0.in_bit = i[0];
      deliver0($sformatf("rr%0d", i), i % 8, i[0]);
      if (i > 0) check_eq($sformatf("rr%0d_spacing", i), 32'(acc_cyc - prev), 3);
      if (i == 3) begin
        check_eq("rr_busy",  32'(busy0), 1);
        check_eq("rr_nrdy",  32'(b0.in_ready), 0);
      end
    end

    // Sparse mask; last grant was 1.
    b0.chan_mask = 8'b1010_0100;
    for (int i = 0; i < 4; i++) begin
      b0.in_bit = 1'b1;
      deliver0($sformatf("sp%0d", i), seq_sparse[i], 1'b1);
    end
    b0.chan_mask = 8'h01;
    @(negedge clk);
    check_eq("mid_addr", 32'(b0.out_addr), 2);
    check_eq("mid_stb",  32'(b0.out_strobe), 0);
    check_eq("gap_busy", 32'(busy0), 1);
    deliver0("mask01", 0, 1'b1);

    // Explicit mode: masked target dropped, enabled target delivered.
    b0.in_valid = 1'b0;
    wait_ready0("ex_idle");
    b0.mode = 1'b1; b0.chan_mask = 8'hF0; b0.in_addr = 3'd3; b0.in_bit = 1'b1;
    b0.in_valid = 1'b1;
    @(negedge clk);
    check_eq("drop_err",  32'(err0), 1);
    check_eq("drop_stb",  32'(b0.out_strobe), 0);
    check_eq("drop_busy", 32'(busy0), 0);
    b0.in_valid = 1'b0;
    @(negedge clk);
    check_eq("drop_pulse", 32'(err0), 0);
    b0.in_addr = 3'd6;
    b0.in_valid = 1'b1;
    deliver0("ex6", 6, 1'b1);
    b0.in_valid = 1'b0;
    @(negedge clk);
    check_eq("ex6_end_stb",  32'(b0.out_strobe), 0);
    check_eq("ex6_end_data", 32'(b0.out_data), 0);
    check_eq("ex6_hold",     32'(b0.out_addr), 6);

    // Zero data bit: round-robin continues from last grant 0.
    b0.mode = 1'b0; b0.chan_mask = 8'hFF; b0.in_bit = 1'b0;
    b0.in_valid = 1'b1;
    deliver0("zero", 1, 1'b0);
    b0.in_valid = 1'b0;
    wait_ready0("z_idle");
    b0.chan_mask = 8'h00;
    b0.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("nomask_rdy%0d", i), 32'(b0.in_ready), 0);
      check_eq($sformatf("nomask_busy%0d", i), 32'(busy0), 0);
    end
    b0.in_valid = 1'b0;

`ifdef DEMUX_ROUTE_STATS_EN
    ssel0 = 3'd2;
    #1;
    check_eq("stat_ch2", 32'(scnt0), 3);
    check_eq("drop_cnt_pre", 32'(dcnt0), 1);
    b0.mode = 1'b1; b0.chan_mask = 8'h10; b0.in_addr = 3'd4; b0.in_bit = 1'b1;
    b0.in_valid = 1'b1;
    repeat (300 * 3 + 6) @(negedge clk);
    b0.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    ssel0 = 3'd4;
    #1;
    check_eq("stat_ch4_sat", 32'(scnt0), 255);
    check_eq("drop_cnt", 32'(dcnt0), 1);
`endif

    // Long strobe, no gap.
    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b1;
    check_eq("p_rdy0", 32'(b1.in_ready), 1);
    a1 = cyc;
    @(negedge clk);
    check_eq("p_addr0", 32'(b1.out_addr), 0);
    w = 0;
    while (b1.out_strobe && w < 10) begin
      w++;
      @(negedge clk);
    end
    check_eq("p_width", 32'(w), 3);
    check_eq("p_rdy1", 32'(b1.in_ready), 1);
    check_eq("p_spacing", 32'(cyc - a1), 4);
    @(negedge clk);
    check_eq("p_stb1",  32'(b1.out_strobe), 1);
    check_eq("p_addr1", 32'(b1.out_addr), 1);
    @(negedge clk);
    check_eq("p_stb1b", 32'(b1.out_strobe), 1);
    rst1_n = 1'b0;
    #1;
    check_eq("mr_stb",  32'(b1.out_strobe), 0);
    check_eq("mr_addr", 32'(b1.out_addr), 0);
    check_eq("mr_data", 32'(b1.out_data), 0);
    check_eq("mr_busy", 32'(busy1), 0);
    check_eq("mr_err",  32'(err1), 0);
    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
    check_eq("pr_stb",  32'(b1.out_strobe), 1);
    check_eq("pr_addr", 32'(b1.out_addr), 0);
    b1.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_route_sequencer.md
Name: demux_route_sequencer

Overview:
- Upstream feeder for the 8-way demux tree.
- Accepts single-bit data words over a valid/ready handshake and picks a destination channel, either round-robin or from an explicit address.
- Drives the demux select address and the gated data bit for a fixed strobe window, then inserts a guard gap.
- Outputs connect directly to the demux select inputs (out_addr) and data/enable input (out_data).

Parameters:
- NCH, 8, number of demux channels; a power of two, minimum 2.
- AW, 3, address width; must equal log2(NCH).
- STROBE_LEN, 1, cycles out_strobe is held high per delivery; minimum 1.
- GAP_CYCLES, 1, idle cycles after each strobe before the next accept; 0 is allowed.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept this cycle.
- in_bit  in  1  data bit to route.
- in_addr  in  AW  explicit destination; used only when mode=1.
- mode  in  1  0 = round-robin, 1 = explicit address.
- chan_mask  in  NCH  1 = channel enabled.
- out_addr  out  AW  demux select address.
- out_data  out  1  demux data bit; forced 0 outside the strobe.
- out_strobe  out  1  delivery window active.
- busy  out  1  state is not IDLE.
- err_drop  out  1  one-cycle pulse when an accepted word is dropped.

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_addr=0, out_data=0, out_strobe=0, err_drop=0, busy=0.
  - last_ptr resets to NCH-1, so the first round-robin grant is channel 0.
- States: IDLE, DRIVE, GAP.
- IDLE:
  - in_ready=1 if mode=1, or if mode=0 and chan_mask is non-zero. Otherwise in_ready=0.
  - Accept occurs when in_valid and in_ready are both high on a clock edge.
  - mode=1, chan_mask[in_addr]=1: latch in_addr and in_bit; go to DRIVE.
  - mode=1, chan_mask[in_addr]=0: word is consumed and dropped; err_drop=1 next cycle; stay in IDLE; last_ptr unchanged.
  - mode=0: grant the first enabled channel strictly after last_ptr, wrapping modulo NCH. last_ptr is set to the grant. Go to DRIVE.
    - A single enabled channel is granted repeatedly.
- DRIVE:
  - Lasts exactly STROBE_LEN cycles, starting the cycle after accept. Latency from accept edge to out_strobe=1 is 1 cycle.
  - out_strobe=1; out_data=latched bit; out_addr is stable for the whole window.
  - in_ready=0.
  - After the window, go to GAP, or directly to IDLE if GAP_CYCLES=0.
- GAP:
  - GAP_CYCLES cycles with out_strobe=0, out_data=0, in_ready=0; out_addr holds its last value. Then go to IDLE.
- Throughput: one word per 1+STROBE_LEN+GAP_CYCLES cycles.
- Sampling rules:
  - chan_mask, mode and in_addr are sampled only at the accept edge. Changes during DRIVE or GAP have no effect on the current delivery.
  - in_valid dropping while in_ready=0 is legal; nothing is accepted.
- Reset asserted mid-DRIVE: the strobe terminates immediately and all outputs take their reset values. The in-flight word is lost with no error pulse.
- busy=1 in DRIVE and GAP.
- The strobe counter width is the minimum width holding max(STROBE_LEN, GAP_CYCLES).

Optional Feature:
- Macro: DEMUX_ROUTE_STATS_EN.
- Defined:
  - Adds ports stat_sel (in, AW) and stat_count (out, 8).
  - Keeps a per-channel 8-bit saturating delivery counter, incremented on the first DRIVE cycle of each delivery.
  - stat_count is a combinational read of counter[stat_sel].
  - Counters reset to 0 and saturate at 255.
  - Also adds drop_count (out, 8), a saturating counter incremented with every err_drop pulse.
- Undefined: these ports and registers are absent; the behaviour above is unchanged.

Decomposition:
- Package demux_route_pkg:
  - state enum (IDLE, DRIVE, GAP);
  - default NCH/AW constants;
  - STAT_W=8.
- Sub-module rr_next_chan (combinational):
  - inputs: mask[NCH], last_ptr[AW];
  - outputs: grant[AW] and any_valid;
  - rotate-then-priority search.
- The top level holds the FSM, counters and output registers.

Test Plan:
- Round-robin walk: mode=0, chan_mask=8'hFF, 10 words with in_valid held high.
  - out_addr sequence 0,1,...,7,0,1.
  - Accepts every 3 cycles with default parameters.
- Sparse mask: mode=0, chan_mask=8'b1010_0100, 4 words.
  - Grants 2,5,7,2.
  - Changing chan_mask to 8'h01 mid-DRIVE leaves the current addr unchanged; the next grant is 0.
- Explicit drop: mode=1, chan_mask=8'hF0.
  - in_addr=3, bit=1: dropped; err_drop pulses once; no strobe.
  - in_addr=6, bit=1: out_addr=6, out_data=1 for 1 cycle.
- Zero data and mask: mode=0, in_bit=0: strobe fires and out_data stays 0.
  - chan_mask=0: in_ready held at 0 for 5 cycles with in_valid=1; nothing accepted.
- Parameter and reset: STROBE_LEN=3, GAP_CYCLES=0.
  - Strobe width is 3; the next accept is on the 4th cycle after the previous accept.
  - rst_n pulsed low during the 2nd strobe cycle: outputs are 0 immediately; the first grant after release is channel 0.
- With DEMUX_ROUTE_STATS_EN: 300 deliveries to channel 4 and 1 drop.
  - stat_sel=4 gives stat_count=255; drop_count=1.
